msrv32_integer_file: RTL and testbench
======================================

Name: msrv32_integer_file

Overview:
- 32 x 32-bit RV32I integer register file, directly downstream of msrv32_wr_en_generator.
- Write enable comes from wr_en_int_file_out, already gated by pipeline flush. Destination address and write-back data come from the stage-3 pipeline register and the write-back mux.
- Provides two combinational read ports (rs1, rs2) to the decode/execute stage.
- x0 is hardwired to zero. An optional same-cycle write-to-read bypass exists.

Parameters:
- DATA_WIDTH, 32, width of each register and of the read/write data.
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH (32 entries).

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on rising edge.
- ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset.
- rs_1_addr_in  input  ADDR_WIDTH  read port 1 address.
- rs_2_addr_in  input  ADDR_WIDTH  read port 2 address.
- rd_addr_in  input  ADDR_WIDTH  write address.
- wr_en_in  input  1  write enable; connect to wr_en_int_file_out.
- rd_in  input  DATA_WIDTH  write data from the write-back mux.
- rs_1_out  output  DATA_WIDTH  read data, port 1.
- rs_2_out  output  DATA_WIDTH  read data, port 2.

Behaviour:
- One clock domain, ms_riscv32_mp_clk_in. Reset is synchronous and active-high on ms_riscv32_mp_rst_in.
- Storage: array reg_file[1..31]. x0 has no storage.
- Reset: on a rising edge with rst=1, every entry 1..31 is set to 0. Reset has priority over any write in the same cycle; that write is dropped.
- Write: on a rising edge with rst=0, wr_en_in=1 and rd_addr_in!=0, reg_file[rd_addr_in] <= rd_in. New contents are visible from the next cycle.
- Writes to x0 are ignored and leave no state change.
- wr_en_in=0: no state change, regardless of rd_addr_in or rd_in.
- Read latency: zero. rs_N_out is a combinational function of rs_N_addr_in and the current array contents.
- rs_N_addr_in==0 always yields 0, including during reset, with or without bypass.
- Both ports may address the same register; each returns identical data.
- Output values after reset: rs_1_out=0 and rs_2_out=0 for any address once one reset edge has occurred.
- Before the first reset edge, contents are undefined, except that x0 reads 0.
- Reset asserted mid-stream (e.g. between back-to-back writes) clears all state on that edge. The write presented in the reset cycle is lost. Writes resume the cycle after rst deasserts.
- No X propagation from x0. All widths are exact, with no sign or zero extension inside the block.

Optional Feature:
- Macro: INT_FILE_BYPASS_EN.
- Defined: write-through bypass is enabled.
  - Condition: rst=0, wr_en_in=1, rd_addr_in!=0 and rs_N_addr_in==rd_addr_in.
  - Response: rs_N_out = rd_in combinationally in the same cycle, not the stale array value.
  - Applies to each port independently, and to both ports together when both match.
  - Bypass is suppressed while rst=1 and when rd_addr_in==0.
- Undefined: no bypass. A read of the register being written returns the old value in that cycle and the new value from the next cycle.
- Array update timing is identical in both builds.

Test Plan:
- Reset clearing: write x5=32'hDEADBEEF, then pulse rst one cycle, then read rs1=5, rs2=31 -> both outputs 32'h0.
- Basic write/read: wr_en=1, rd=10, data=32'h1234_5678, one edge; then wr_en=0, rs1=10, rs2=10 -> both 32'h1234_5678. Also check x9 and x11 remain 0.
- x0 protection: wr_en=1, rd=0, data=32'hFFFF_FFFF, one edge; then rs1=0 -> 32'h0 (also while wr_en=1, rd=0 is presented).
- Gated write (flush upstream): wr_en=0, rd=7, data=32'hA5A5_A5A5 for several edges -> rs1=7 reads 32'h0.
- Reset priority: rst=1, wr_en=1, rd=3, data=32'h55 on the same edge -> x3 reads 32'h0 the next cycle. Then rst=0 with the same write -> x3 reads 32'h55 the next cycle.
- Same-cycle read of written register: x12=32'h11, then present wr_en=1, rd=12, data=32'h22 with rs1=rs2=12 before the edge.
  - With INT_FILE_BYPASS_EN: rs1_out=rs2_out=32'h22.
  - Without it: 32'h11.
  - Both builds read 32'h22 after the edge.

Source files
------------

// File: rtl/msrv32_integer_file.sv
// RV32I integer register file: 32 x DATA_WIDTH, x0 hardwired to zero, two read ports, one write port.
// Latency: reads combinational (zero cycles); writes visible the cycle after the write edge.
// Backpressure: none, always accepts; writes gated only by wr_en_in. Define INT_FILE_BYPASS_EN for write-through reads.
module msrv32_integer_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_in,
    input  logic [ADDR_WIDTH-1:0] rs_1_addr_in,
    input  logic [ADDR_WIDTH-1:0] rs_2_addr_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    input  logic                  wr_en_in,
    input  logic [DATA_WIDTH-1:0] rd_in,
    output logic [DATA_WIDTH-1:0] rs_1_out,
    output logic [DATA_WIDTH-1:0] rs_2_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // No storage for x0; every read of address 0 is forced to zero below.
    logic [DATA_WIDTH-1:0] reg_file [1:DEPTH-1];
    logic                  wr_fire;

    assign wr_fire = wr_en_in && (rd_addr_in != '0);

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            for (int i = 1; i < DEPTH; i++) begin
                reg_file[i] <= '0;
            end
        end else if (wr_fire) begin
            reg_file[rd_addr_in] <= rd_in;
        end
    end

    always_comb begin
        rs_1_out = '0;
        rs_2_out = '0;
        if (rs_1_addr_in != '0) begin
            rs_1_out = reg_file[rs_1_addr_in];
        end
        if (rs_2_addr_in != '0) begin
            rs_2_out = reg_file[rs_2_addr_in];
        end
`ifdef INT_FILE_BYPASS_EN
        // wr_fire already excludes rd==0, so a matching address is never x0.
        if (!ms_riscv32_mp_rst_in && wr_fire && (rs_1_addr_in == rd_addr_in)) begin
            rs_1_out = rd_in;
        end
        if (!ms_riscv32_mp_rst_in && wr_fire && (rs_2_addr_in == rd_addr_in)) begin
            rs_2_out = rd_in;
        end
`endif
    end

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Self-checking bench for msrv32_integer_file: vector table, mid-stream reset sequence, random model phase.
module tb_msrv32_integer_file;

`ifdef INT_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rs1_a = '0;
    logic [4:0]  rs2_a = '0;
    logic [4:0]  rd_a = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rs1_d;
    logic [31:0] rs2_d;

    int n_checks = 0;
    int n_fail = 0;

    msrv32_integer_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .rs_1_addr_in         (rs1_a),
        .rs_2_addr_in         (rs2_a),
        .rd_addr_in           (rd_a),
        .wr_en_in             (we),
        .rd_in                (wd),
        .rs_1_out             (rs1_d),
        .rs_2_out             (rs2_d)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct packed {
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, queue its expected reads, compare before the rising edge.
    task automatic step(input string name, input logic r, input logic w, input logic [4:0] rd,
                        input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] e1, input logic [31:0] e2);
        exp_t got_exp;
        @(negedge clk);
        rst = r; we = w; rd_a = rd; wd = d; rs1_a = a1; rs2_a = a2;
        sb_q.push_back('{e1: e1, e2: e2});
        #2;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty got 0 expected 1 entry", name);
        end else begin
            got_exp = sb_q.pop_front();
            check({name, ".rs1"}, rs1_d, got_exp.e1);
            check({name, ".rs2"}, rs2_d, got_exp.e2);
        end
    endtask

    function automatic logic [31:0] byp(input logic [31:0] new_v, input logic [31:0] old_v);
        return BYPASS ? new_v : old_v;
    endfunction

    logic [31:0] model [32];

    initial begin
        //          rst  we   rd     data           a1     a2     e1                          e2
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,                      32'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF,  5'd31, 5'd0,  32'h0,                      32'h0};
        vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,         5'd5,  5'd0,  32'hDEADBEEF,               32'h0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd5,  5'd31, 32'h0,                      32'h0};
        vecs[4]  = '{1'b0, 1'b1, 5'd10, 32'h12345678,  5'd9,  5'd11, 32'h0,                      32'h0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd10, 5'd10, 32'h12345678,               32'h12345678};
        vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd9,  5'd11, 32'h0,                      32'h0};
        vecs[7]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF,  5'd0,  5'd0,  32'h0,                      32'h0};
        vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd0,  5'd10, 32'h0,                      32'h12345678};
        vecs[9]  = '{1'b0, 1'b0, 5'd7,  32'hA5A5A5A5,  5'd7,  5'd7,  32'h0,                      32'h0};
        vecs[10] = '{1'b0, 1'b0, 5'd7,  32'hA5A5A5A5,  5'd7,  5'd7,  32'h0,                      32'h0};
        vecs[11] = '{1'b0, 1'b0, 5'd7,  32'hA5A5A5A5,  5'd7,  5'd7,  32'h0,                      32'h0};
        vecs[12] = '{1'b1, 1'b1, 5'd3,  32'h55,        5'd3,  5'd0,  32'h0,                      32'h0};
        vecs[13] = '{1'b0, 1'b1, 5'd3,  32'h55,        5'd3,  5'd10, byp(32'h55, 32'h0),         32'h0};
        vecs[14] = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd3,  5'd3,  32'h55,                     32'h55};
        vecs[15] = '{1'b0, 1'b1, 5'd12, 32'h11,        5'd0,  5'd3,  32'h0,                      32'h55};
        vecs[16] = '{1'b0, 1'b1, 5'd12, 32'h22,        5'd12, 5'd12, byp(32'h22, 32'h11),        byp(32'h22, 32'h11)};
        vecs[17] = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd12, 5'd12, 32'h22,                     32'h22};

        for (int i = 0; i < 18; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].we, vecs[i].rd, vecs[i].data,
                 vecs[i].a1, vecs[i].a2, vecs[i].e1, vecs[i].e2);
        end

        // Reset landing between back-to-back writes drops only the write in its own cycle.
        step("ms_w20",   1'b0, 1'b1, 5'd20, 32'h1, 5'd0,  5'd0,  32'h0, 32'h0);
        step("ms_w21",   1'b1, 1'b1, 5'd21, 32'h2, 5'd20, 5'd0,  32'h1, 32'h0);
        step("ms_w22",   1'b0, 1'b1, 5'd22, 32'h3, 5'd20, 5'd21, 32'h0, 32'h0);
        step("ms_read",  1'b0, 1'b0, 5'd0,  32'h0, 5'd22, 5'd21, 32'h3, 32'h0);
        step("ms_read2", 1'b0, 1'b0, 5'd0,  32'h0, 5'd12, 5'd20, 32'h0, 32'h0);

        // Random traffic against a reference array, starting from a fresh reset.
        step("rnd_rst", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int i = 0; i < 200; i++) begin
            logic        w;
            logic [4:0]  rd, a1, a2;
            logic [31:0] d, e1, e2;
            w  = ($urandom_range(0, 3) != 0);
            rd = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            a2 = (i % 4 == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 7));
            d  = $urandom();
            e1 = (a1 == 0) ? 32'h0 : ((BYPASS && w && rd != 0 && rd == a1) ? d : model[a1]);
            e2 = (a2 == 0) ? 32'h0 : ((BYPASS && w && rd != 0 && rd == a2) ? d : model[a2]);
            step($sformatf("rnd%0d", i), 1'b0, w, rd, d, a1, a2, e1, e2);
            if (w && rd != 0) model[rd] = d;
        end

        @(negedge clk);
        we = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
